fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the pipelined core's IF/ID register.
- Owns the fetch PC and drives the registered instruction ROM, which has 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and hands them to the core over a valid/ready handshake.
- Accepts branch redirects from the core's MEM stage and discards every wrong-path instruction.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue_if.sv | 15 +
 rtl/fetch_queue_fifo.sv | 53 +++++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end (package fetch_pkg).
package fetch_pkg;

    localparam int FQ_DATA_SIZE = 32;
    localparam int FQ_ADDR_SIZE = 10;
    localparam int FQ_PC_SIZE   = FQ_ADDR_SIZE + 2;

    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam int          PC_STEP  = 4;

    typedef struct packed {
        logic [FQ_DATA_SIZE-1:0] inst;
        logic [FQ_PC_SIZE-1:0]   pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction hand-off between the fetch queue (master) and the core IF/ID stage (slave).
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DATA_SIZE = FQ_DATA_SIZE,
    parameter int ADDR_SIZE = FQ_ADDR_SIZE
);
    logic                 inst_valid;
    logic                 inst_ready;
    logic [DATA_SIZE-1:0] inst;
    logic [ADDR_SIZE+1:0] inst_pc;

    modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of tagged instructions (module fetch_fifo); flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  fq_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fq_entry_t              head
);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, ROM request tracking and instruction queue in front of the core IF/ID register.
// Optional FETCH_QUEUE_PERF_EN adds saturating redirect/stall counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_SIZE = FQ_DATA_SIZE,
    parameter int ADDR_SIZE = FQ_ADDR_SIZE,
    parameter int DEPTH     = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   redirect_valid,
    input  logic [ADDR_SIZE+1:0]   redirect_pc,
    output logic [ADDR_SIZE-1:0]   iaddr,
    input  logic [DATA_SIZE-1:0]   idata,
    output logic [$clog2(DEPTH):0] occupancy,
    fetch_queue_if.master          core
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]            redirect_count,
    output logic [15:0]            stall_count
`endif
);
    localparam int PCW = ADDR_SIZE + 2;
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [PCW-1:0] fetch_pc;
    logic [PCW-1:0] req_pc;
    logic           req_pending;
    logic           pop;
    logic           issue;
    logic [CW:0]    credit;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  count;
    fq_entry_t      push_entry;
    fq_entry_t      head;

    // Entries already queued or in flight from the ROM, less the one leaving now.
    assign pop    = core.inst_valid & core.inst_ready;
    assign credit = {1'b0, count} + (CW+1)'(req_pending) - (CW+1)'(pop);
    assign issue  = ~redirect_valid & (credit < (CW+1)'(DEPTH));

    assign push_entry.inst = idata;
    assign push_entry.pc   = req_pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (req_pending),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (count),
        .head       (head)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc    <= '0;
            req_pc      <= '0;
            req_pending <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[PCW-1:2], 2'b00};
            req_pending <= 1'b0;
        end else begin
            req_pending <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PCW'(PC_STEP);
            end
        end
    end

    assign iaddr           = fetch_pc[PCW-1:2];
    assign occupancy       = count;
    assign core.inst_valid = ~fifo_empty;
    assign core.inst       = fifo_empty ? DATA_SIZE'(NOP_INST) : head.inst;
    assign core.inst_pc    = fifo_empty ? '0 : head.pc;

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            redirect_count <= '0;
            stall_count    <= '0;
        end else begin
            if (redirect_valid && (redirect_count != 16'hFFFF))
                redirect_count <= redirect_count + 16'd1;
            if (core.inst_valid && !core.inst_ready && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DS    = 32;
    localparam int AS    = 10;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic [9:0]  iaddr;
    logic [31:0] idata;
    logic [2:0]  occupancy;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] redirect_count;
    logic [15:0] stall_count;
`endif

    fetch_queue_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) fq_bus ();

    fetch_queue #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .iaddr          (iaddr),
        .idata          (idata),
        .occupancy      (occupancy),
        .core           (fq_bus.master)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'h1000 + {22'd0, a};
    endfunction

    always @(posedge CLK) idata <= rom_word(iaddr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of delivered entries plus the one outstanding ROM read.
    typedef struct {
        logic [31:0] inst;
        logic [11:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend = 0;
    logic [11:0] m_req_pc = '0;
    logic [11:0] m_fetch_pc = '0;
    int          m_rc = 0;
    int          m_sc = 0;

    always @(negedge CLK) begin
        bit          e_valid;
        bit          pop;
        bit          issue;
        int          credit;
        ent_t        e;
        if (RESET) begin
            mq.delete();
            m_pend     = 0;
            m_req_pc   = '0;
            m_fetch_pc = '0;
            m_rc       = 0;
            m_sc       = 0;
        end
        e_valid = (mq.size() > 0);
        chk("inst_valid", fq_bus.inst_valid, e_valid);
        chk("inst", fq_bus.inst, e_valid ? mq[0].inst : NOP_INST);
        chk("inst_pc", fq_bus.inst_pc, e_valid ? mq[0].pc : 12'h000);
        chk("occupancy", occupancy, mq.size());
        chk("iaddr", iaddr, m_fetch_pc[11:2]);
`ifdef FETCH_QUEUE_PERF_EN
        chk("redirect_count", redirect_count, m_rc);
        chk("stall_count", stall_count, m_sc);
`endif
        if (!RESET) begin
            pop = e_valid && fq_bus.inst_ready;
            if (e_valid && !fq_bus.inst_ready && m_sc < 16'hFFFF) m_sc++;
            if (redirect_valid) begin
                if (m_rc < 16'hFFFF) m_rc++;
                mq.delete();
                m_pend     = 0;
                m_fetch_pc = redirect_pc & 12'hFFC;
            end else begin
                credit = mq.size() + int'(m_pend) - int'(pop);
                issue  = (credit < DEPTH);
                if (pop) void'(mq.pop_front());
                if (m_pend) begin
                    if (mq.size() >= DEPTH) chk("push_into_full", mq.size(), DEPTH - 1);
                    e.inst = rom_word(m_req_pc[11:2]);
                    e.pc   = m_req_pc;
                    mq.push_back(e);
                end
                m_pend = issue;
                if (issue) begin
                    m_req_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 12'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        redirect_valid = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        fq_bus.inst_ready = 1'b1;
        repeat (3) tick();

        // Reset release latency and streaming
        RESET = 1'b0;
        chk("lat_c0_valid", fq_bus.inst_valid, 0);
        tick();
        chk("lat_c1_valid", fq_bus.inst_valid, 0);
        tick();
        chk("lat_c2_valid", fq_bus.inst_valid, 1);
        chk("lat_c2_inst", fq_bus.inst, 32'h1000);
        chk("lat_c2_pc", fq_bus.inst_pc, 12'h000);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("stream_pc", fq_bus.inst_pc, 12'(k * 4));
            chk("stream_inst", fq_bus.inst, 32'h1000 + 32'(k));
        end

        // Async reset takes effect without a clock edge
        RESET = 1'b1;
        #1;
        chk("async_rst_valid", fq_bus.inst_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_inst", fq_bus.inst, NOP_INST);
        tick();

        // Stall fills the queue, fetch stops at 0x010
        fq_bus.inst_ready = 1'b0;
        RESET = 1'b0;
        repeat (10) tick();
        chk("stall_occ", occupancy, 4);
        chk("stall_iaddr", iaddr, 10'h004);
        chk("stall_inst", fq_bus.inst, 32'h1000);
        fq_bus.inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_pc", fq_bus.inst_pc, 12'(k * 4));
            tick();
        end

        // Redirect with the queue half full and a pop in the same cycle
        fq_bus.inst_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        chk("half_occ", occupancy, 2);
        fq_bus.inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 12'h103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_occ", occupancy, 0);
        tick();
        chk("redir_c2_valid", fq_bus.inst_valid, 0);
        tick();
        chk("redir_c3_valid", fq_bus.inst_valid, 1);
        chk("redir_c3_pc", fq_bus.inst_pc, 12'h100);
        chk("redir_c3_inst", fq_bus.inst, 32'h1040);
        repeat (3) tick();

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_pc = 12'h200;
        tick();
        chk("b2b_occ1", occupancy, 0);
        redirect_pc = 12'h300;
        tick();
        chk("b2b_occ2", occupancy, 0);
        redirect_valid = 1'b0;
        tick();
        chk("b2b_valid_early", fq_bus.inst_valid, 0);
        tick();
        chk("b2b_pc", fq_bus.inst_pc, 12'h300);
        chk("b2b_inst", fq_bus.inst, 32'h10C0);

        // Wrap from 0xFFC to 0x000
        redirect_valid = 1'b1;
        redirect_pc = 12'hFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("wrap_pc0", fq_bus.inst_pc, 12'hFF8);
        chk("wrap_inst0", fq_bus.inst, 32'h13FE);
        tick();
        chk("wrap_pc1", fq_bus.inst_pc, 12'hFFC);
        tick();
        chk("wrap_pc2", fq_bus.inst_pc, 12'h000);
        chk("wrap_inst2", fq_bus.inst, 32'h1000);
        tick();
        chk("wrap_pc3", fq_bus.inst_pc, 12'h004);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fq_bus.inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = 12'($urandom);
            if ($urandom_range(0, 599) == 0) RESET = 1'b1;
            tick();
            RESET = 1'b0;
        end
        redirect_valid = 1'b0;
        fq_bus.inst_ready = 1'b1;
        tick();

`ifdef FETCH_QUEUE_PERF_EN
        do_reset();
        fq_bus.inst_ready = 1'b1;
        tick();
        tick();
        fq_bus.inst_ready = 1'b0;
        repeat (7) tick();
        fq_bus.inst_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            redirect_valid = 1'b1;
            redirect_pc = 12'h040;
            tick();
            redirect_valid = 1'b0;
            tick();
        end
        chk("perf_redirects", redirect_count, 3);
        chk("perf_stalls", stall_count, 7);
        repeat (3) tick();
        fq_bus.inst_ready = 1'b0;
        repeat (70000) tick();
        chk("perf_stall_sat", stall_count, 16'hFFFF);
        RESET = 1'b1;
        #1;
        chk("perf_rst_rc", redirect_count, 0);
        chk("perf_rst_sc", stall_count, 0);
        chk("perf_rst_valid", fq_bus.inst_valid, 0);
        tick();
        RESET = 1'b0;
        fq_bus.inst_ready = 1'b1;
        repeat (4) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
